// File: rtl/dvi_deserialiser.sv
// dvi_deserialiser
//   Recovers 10-bit TMDS symbols from a DDR-captured serial stream running at
//   five times the pixel rate. Two bits arrive per clk_x5 cycle. A 20-bit
//   history is kept, and once every five cycles a 10-bit window at bit offset
//   `off` is extracted. A two-state alignment FSM watches for runs of TMDS
//   control tokens. It slips the offset by one bit when a search window
//   expires without lock, and it drops lock when no control token has been
//   seen for LOSS_TIMEOUT symbols.
//
// Parameters
//   LOCK_COUNT   consecutive control tokens at one offset needed to lock
//   SEARCH_LEN   symbols evaluated at one offset before slipping
//   LOSS_TIMEOUT symbols without a control token before lock is dropped
//
// Ports
//   clk_x5      in   bit clock (5x pixel rate), rising edge only
//   rst_n_x5    in   asynchronous active-low reset
//   d_rise      in   earlier bit of the DDR pair
//   d_fall      in   later bit of the DDR pair
//   resync      in   pulse: abandon alignment, advance offset, search again
//   sym[9:0]    out  recovered symbol, bit 0 first on the wire
//   sym_valid   out  one-cycle strobe, once every 5 cycles
//   sym_is_ctrl out  sym is a TMDS control token (qualified by sym_valid)
//   ctrl[1:0]   out  decoded {c1,c0} for control tokens, else 2'b00
//   locked      out  alignment FSM is in LOCKED
module dvi_deserialiser #(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_LEN   = 1024,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_x5,
  input  logic       rst_n_x5,
  input  logic       d_rise,
  input  logic       d_fall,
  input  logic       resync,
  output logic [9:0] sym,
  output logic       sym_valid,
  output logic       sym_is_ctrl,
  output logic [1:0] ctrl,
  output logic       locked
);

  // The run counter has to hold LOCK_COUNT itself. The timer and the loss
  // counter only ever reach their parameter minus one.
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W  = (SEARCH_LEN   > 2) ? $clog2(SEARCH_LEN)   : 1;
  localparam int LOSS_W = (LOSS_TIMEOUT > 2) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_COUNT);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_LEN - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] TOK_00 = 10'h354;
  localparam logic [9:0] TOK_01 = 10'h0AB;
  localparam logic [9:0] TOK_10 = 10'h154;
  localparam logic [9:0] TOK_11 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [19:0]       r_sr;
  logic [2:0]        r_phase;
  logic              r_primed;
  logic [3:0]        r_off;
  logic [9:0]        r_sym;
  logic              r_sym_valid;
  logic              r_sym_is_ctrl;
  logic [1:0]        r_ctrl;
  state_t            r_state;
  logic [RUN_W-1:0]  r_run;
  logic [TMR_W-1:0]  r_timer;
  logic [LOSS_W-1:0] r_loss;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic [9:0]        w_window;
  logic              w_is_ctrl;
  logic [1:0]        w_ctrl;
  logic              w_load;
  logic [3:0]        w_off_inc;
  logic [RUN_W-1:0]  w_run_next;
  logic [TMR_W-1:0]  w_timer_inc;
  logic [LOSS_W-1:0] w_loss_inc;

  // The window is taken from the registered history, so an offset change
  // only affects symbols extracted after it.
  assign w_window = 10'(r_sr >> r_off);

  // On the first phase-0 edge after reset the history holds no post-reset
  // bits yet, so that extraction is skipped. This keeps the first strobe six
  // cycles after release.
  assign w_load = (r_phase == 3'd0) && r_primed;

  assign w_off_inc = (r_off == 4'd9) ? 4'd0 : r_off + 4'd1;

  // All counters saturate at their terminal value instead of wrapping.
  assign w_run_next  = !r_sym_is_ctrl      ? '0 :
                       (r_run == RUN_LOCK) ? r_run : r_run + RUN_W'(1);
  assign w_timer_inc = (r_timer == TMR_LAST)  ? r_timer : r_timer + TMR_W'(1);
  assign w_loss_inc  = (r_loss  == LOSS_LAST) ? r_loss  : r_loss + LOSS_W'(1);

  always_comb begin
    w_is_ctrl = 1'b0;
    w_ctrl    = 2'b00;
    case (w_window)
      TOK_00:  begin w_is_ctrl = 1'b1; w_ctrl = 2'b00; end
      TOK_01:  begin w_is_ctrl = 1'b1; w_ctrl = 2'b01; end
      TOK_10:  begin w_is_ctrl = 1'b1; w_ctrl = 2'b10; end
      TOK_11:  begin w_is_ctrl = 1'b1; w_ctrl = 2'b11; end
      default: begin w_is_ctrl = 1'b0; w_ctrl = 2'b00; end
    endcase
  end

  // ---------------------------------------------------------------------
  // Capture, phase and symbol extraction
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_sr          <= '0;
      r_phase       <= '0;
      r_primed      <= 1'b0;
      r_sym         <= '0;
      r_sym_valid   <= 1'b0;
      r_sym_is_ctrl <= 1'b0;
      r_ctrl        <= '0;
    end else begin
      // The newest pair enters at the top, so r_sr[0] is the oldest bit.
      r_sr        <= {d_fall, d_rise, r_sr[19:2]};
      r_phase     <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
      r_primed    <= 1'b1;
      r_sym_valid <= w_load;
      if (w_load) begin
        r_sym         <= w_window;
        r_sym_is_ctrl <= w_is_ctrl;
        r_ctrl        <= w_ctrl;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Alignment FSM: evaluated in the strobe cycle of each symbol. resync
  // overrides everything, so it can never stack with a slip or a lock.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_state <= ST_SEARCH;
      r_off   <= '0;
      r_run   <= '0;
      r_timer <= '0;
      r_loss  <= '0;
    end else if (resync) begin
      r_state <= ST_SEARCH;
      r_off   <= w_off_inc;
      r_run   <= '0;
      r_timer <= '0;
      r_loss  <= '0;
    end else if (r_sym_valid) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_run_next == RUN_LOCK) begin
            r_state <= ST_LOCKED;
            r_loss  <= '0;
            r_run   <= '0;
            r_timer <= '0;
          end else if (r_timer == TMR_LAST) begin
            // Window expired at this offset: try the next bit position.
            r_off   <= w_off_inc;
            r_timer <= '0;
            r_run   <= '0;
          end else begin
            r_timer <= w_timer_inc;
            r_run   <= w_run_next;
          end
        end
        ST_LOCKED: begin
          if (r_sym_is_ctrl) begin
            r_loss <= '0;
          end else if (r_loss == LOSS_LAST) begin
            // Offset is kept. The same alignment is likely still right
            // once blanking returns.
            r_state <= ST_SEARCH;
            r_timer <= '0;
            r_run   <= '0;
            r_loss  <= '0;
          end else begin
            r_loss <= w_loss_inc;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign sym         = r_sym;
  assign sym_valid   = r_sym_valid;
  assign sym_is_ctrl = r_sym_is_ctrl;
  assign ctrl        = r_ctrl;
  assign locked      = (r_state == ST_LOCKED);

endmodule
